// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Control sequencer for a multi-cycle RV32I datapath that
//                executes add/addi/lw/sw and shares a single memory port for
//                instruction fetch and data access. Each instruction walks
//                FETCH -> DECODE -> EXECUTE -> [MEM_ACCESS] -> [WRITEBACK].
//                The sequencer halts on an illegal opcode or when memory
//                fails to acknowledge a request within MEM_TIMEOUT cycles.
//
//  Ports       : clk            system clock, rising edge
//                reset          synchronous, active-high; forces outputs to 0
//                opcode_i[6:0]  instruction[6:0] from the instruction register
//                mem_ack_i      memory finished the current request
//                mem_req_o      memory request, held until ack
//                mem_we_o       1 = store request
//                iord_o         address select: 0 = PC, 1 = ALU result
//                ir_write_o     load instruction register (fetch ack cycle)
//                pc_write_o     PC <= PC+4 (fetch ack cycle)
//                reg_write_o    register-file write enable
//                alu_src_o      ALU B operand: 0 = rs2, 1 = immediate
//                mem_to_reg_o   write-back data: 0 = ALU, 1 = memory
//                alu_op_o[2:0]  000 R-type, 001 I-ALU, 010 address add
//                state_o[2:0]   current state encoding
//                instr_done_o   one-cycle pulse on instruction retire
//                instr_count_o  retired-instruction counter (wraps)
//                error_o        sticky error flag, set on entering HALT
//                error_code_o   00 none, 01 illegal opcode, 10 mem timeout
//
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        reg_write_o,
  output logic        alu_src_o,
  output logic        mem_to_reg_o,
  output logic [2:0]  alu_op_o,
  output logic [2:0]  state_o,
  output logic        instr_done_o,
  output logic [31:0] instr_count_o,
  output logic        error_o,
  output logic [1:0]  error_code_o
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_FETCH      = 3'd0;
  localparam logic [2:0] c_DECODE     = 3'd1;
  localparam logic [2:0] c_EXECUTE    = 3'd2;
  localparam logic [2:0] c_MEM_ACCESS = 3'd3;
  localparam logic [2:0] c_WRITEBACK  = 3'd4;
  localparam logic [2:0] c_HALT       = 3'd7;

  localparam logic [6:0] c_OP_R  = 7'b0110011;
  localparam logic [6:0] c_OP_I  = 7'b0010011;
  localparam logic [6:0] c_OP_LW = 7'b0000011;
  localparam logic [6:0] c_OP_SW = 7'b0100011;

  localparam logic [2:0] c_ALU_R   = 3'b000;
  localparam logic [2:0] c_ALU_I   = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;

  localparam logic [1:0] c_ERR_NONE    = 2'b00;
  localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;

  // Timeout fires when the counter shows MEM_TIMEOUT-1 completed wait cycles
  // and the current cycle is also un-acked, i.e. on the MEM_TIMEOUT-th cycle.
  localparam bit               c_TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] c_WAIT_LAST  =
      (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Registers and internal wires
  // --------------------------------------------------------------------------
  logic [2:0]       r_state;
  logic [6:0]       r_op;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_instr_count;
  logic             r_error;
  logic [1:0]       r_error_code;

  logic [2:0]       w_state_next;
  logic [1:0]       w_halt_code;
  logic             w_halt_entry;
  logic             w_legal;
  logic             w_wait_state;
  logic             w_timeout;
  logic             w_is_lw;
  logic             w_is_sw;
  logic             w_is_i;

  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_iord;
  logic             w_ir_write;
  logic             w_pc_write;
  logic             w_reg_write;
  logic             w_alu_src;
  logic             w_mem_to_reg;
  logic [2:0]       w_alu_op;
  logic             w_instr_done;

  // --------------------------------------------------------------------------
  // Shared decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_legal = (opcode_i == c_OP_R)  || (opcode_i == c_OP_I) ||
              (opcode_i == c_OP_LW) || (opcode_i == c_OP_SW);
  end

  // r_op is only meaningful after DECODE; it selects the EXECUTE/MEM/WB flavour.
  always_comb begin
    w_is_lw = (r_op == c_OP_LW);
    w_is_sw = (r_op == c_OP_SW);
    w_is_i  = (r_op == c_OP_I);
  end

  always_comb begin
    w_wait_state = (r_state == c_FETCH) || (r_state == c_MEM_ACCESS);
    // An ack in the final wait cycle takes priority over the timeout.
    w_timeout    = c_TIMEOUT_EN && w_wait_state && !mem_ack_i &&
                   (r_wait_cnt == c_WAIT_LAST);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_halt_code  = c_ERR_NONE;
    case (r_state)
      c_FETCH: begin
        if (mem_ack_i) begin
          w_state_next = c_DECODE;
        end else if (w_timeout) begin
          w_state_next = c_HALT;
          w_halt_code  = c_ERR_TIMEOUT;
        end
      end
      c_DECODE: begin
        if (w_legal) begin
          w_state_next = c_EXECUTE;
        end else begin
          w_state_next = c_HALT;
          w_halt_code  = c_ERR_ILLEGAL;
        end
      end
      c_EXECUTE: begin
        if (w_is_lw || w_is_sw) begin
          w_state_next = c_MEM_ACCESS;
        end else begin
          w_state_next = c_WRITEBACK;
        end
      end
      c_MEM_ACCESS: begin
        if (mem_ack_i) begin
          w_state_next = w_is_lw ? c_WRITEBACK : c_FETCH;
        end else if (w_timeout) begin
          w_state_next = c_HALT;
          w_halt_code  = c_ERR_TIMEOUT;
        end
      end
      c_WRITEBACK: begin
        w_state_next = c_FETCH;
      end
      c_HALT: begin
        // Only reset leaves HALT.
        w_state_next = c_HALT;
      end
      default: begin
        // Unused encodings recover to a clean fetch.
        w_state_next = c_FETCH;
      end
    endcase
  end

  always_comb begin
    w_halt_entry = (w_state_next == c_HALT) && (r_state != c_HALT);
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore on state/op, except fetch-ack gating)
  // --------------------------------------------------------------------------
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_op     = c_ALU_R;
    w_instr_done = 1'b0;
    case (r_state)
      c_FETCH: begin
        w_mem_req  = 1'b1;
        w_iord     = 1'b0;
        // IR/PC update exactly once, in the cycle the fetch data is valid.
        w_ir_write = mem_ack_i;
        w_pc_write = mem_ack_i;
      end
      c_EXECUTE: begin
        if (w_is_lw || w_is_sw) begin
          w_alu_op  = c_ALU_ADD;
          w_alu_src = 1'b1;
        end else if (w_is_i) begin
          w_alu_op  = c_ALU_I;
          w_alu_src = 1'b1;
        end else begin
          w_alu_op  = c_ALU_R;
          w_alu_src = 1'b0;
        end
      end
      c_MEM_ACCESS: begin
        w_mem_req    = 1'b1;
        w_iord       = 1'b1;
        w_alu_op     = c_ALU_ADD;
        w_alu_src    = 1'b1;
        w_mem_we     = w_is_sw;
        // Stores retire directly from the memory stage once the write lands.
        w_instr_done = w_is_sw && mem_ack_i;
      end
      c_WRITEBACK: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = w_is_lw;
        w_instr_done = 1'b1;
      end
      default: begin
        // DECODE and HALT drive no control signals.
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bookkeeping: latched opcode, wait counter, retire counter, error status
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op          <= '0;
      r_wait_cnt    <= '0;
      r_instr_count <= '0;
      r_error       <= 1'b0;
      r_error_code  <= c_ERR_NONE;
    end else begin
      if (r_state == c_DECODE) begin
        r_op <= opcode_i;
      end

      // The counter only ever runs inside a wait state; any state change or
      // ack restarts it so each request gets a fresh budget.
      if ((w_state_next != r_state) || (w_wait_state && mem_ack_i)) begin
        r_wait_cnt <= '0;
      end else if (w_wait_state) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end

      if (w_instr_done) begin
        r_instr_count <= r_instr_count + 32'd1;
      end

      if (w_halt_entry) begin
        r_error      <= 1'b1;
        r_error_code <= w_halt_code;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive: everything reads 0 while reset is asserted
  // --------------------------------------------------------------------------
  assign mem_req_o     = w_mem_req    & ~reset;
  assign mem_we_o      = w_mem_we     & ~reset;
  assign iord_o        = w_iord       & ~reset;
  assign ir_write_o    = w_ir_write   & ~reset;
  assign pc_write_o    = w_pc_write   & ~reset;
  assign reg_write_o   = w_reg_write  & ~reset;
  assign alu_src_o     = w_alu_src    & ~reset;
  assign mem_to_reg_o  = w_mem_to_reg & ~reset;
  assign alu_op_o      = reset ? 3'b000 : w_alu_op;
  assign state_o       = reset ? 3'b000 : r_state;
  assign instr_done_o  = w_instr_done & ~reset;
  assign instr_count_o = reset ? 32'd0 : r_instr_count;
  assign error_o       = r_error      & ~reset;
  assign error_code_o  = reset ? c_ERR_NONE : r_error_code;

endmodule
`default_nettype wire
